// File: rtl/sprite_line_writer.sv
// sprite_line_writer: per-scanline sprite renderer into a 4bpp line buffer.
// Scans NSPR attribute entries, fetches 16-pixel rows for hits from the
// graphics ROM and writes the opaque pixels into the bank chosen by VPOS[0].
// Optional build macro SPRITE_LIMIT_EN: cap the number of sprites drawn per
// line at MAXLINE and report the extra hits on OVF.
module sprite_line_writer #(
    parameter int unsigned NSPR    = 64,
    parameter int unsigned MAXLINE = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LINE_START,
    input  logic [7:0]  VPOS,
    output logic [7:0]  SPA,
    input  logic [7:0]  SPD,
    output logic [12:0] ROM_AD,
    output logic        ROM_RD,
    input  logic        ROM_OK,
    input  logic [31:0] ROM_DT,
    output logic        WEN,
    output logic [9:0]  WAD,
    output logic [3:0]  WDT,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVF
);

    typedef enum logic [2:0] {
        StIdle,
        StAttr,
        StCheck,
        StFetch,
        StDraw,
        StNext,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  vpos_q, vpos_d;
    logic [5:0]  idx_q, idx_d;
    // Attribute byte step (0..4) in ATTR, pixel index (0..15) in DRAW.
    logic [3:0]  sub_q, sub_d;
    logic [7:0]  y_q, y_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  code_q, code_d;
    logic        hflip_q, hflip_d;
    logic        vflip_q, vflip_d;
    logic [3:0]  row_q, row_d;
    logic        half_q, half_d;
    // Pixel 0 sits in [63:60], pixel 15 in [3:0].
    logic [63:0] pix_q, pix_d;

    logic [7:0]  diff;
    logic [3:0]  pix_slot;
    logic [3:0]  pixel;

`ifdef SPRITE_LIMIT_EN
    logic [6:0]  hit_q, hit_d;
    logic        ovf_q, ovf_d;
    assign OVF = ovf_q;
`else
    logic        unused_maxline;
    assign unused_maxline = (MAXLINE != 0);
    assign OVF = 1'b0;
`endif

    assign diff     = vpos_q - y_q;
    // Slot counted from the LSB end; hflip reads the row back to front.
    assign pix_slot = hflip_q ? sub_q : ~sub_q;
    assign pixel    = pix_q[{pix_slot, 2'b00} +: 4];

    // Next-state, datapath updates and all outputs decoded from the current state.
    always_comb begin
        state_d = state_q;
        vpos_d  = vpos_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        y_d     = y_q;
        x_d     = x_q;
        code_d  = code_q;
        hflip_d = hflip_q;
        vflip_d = vflip_q;
        row_d   = row_q;
        half_d  = half_q;
        pix_d   = pix_q;
`ifdef SPRITE_LIMIT_EN
        hit_d   = hit_q;
        ovf_d   = ovf_q;
`endif
        SPA     = '0;
        ROM_AD  = '0;
        ROM_RD  = 1'b0;
        WEN     = 1'b0;
        WAD     = '0;
        WDT     = '0;
        BUSY    = 1'b0;
        DONE    = 1'b0;

        case (state_q)
            StIdle: begin
            end
            StAttr: begin
                BUSY = 1'b1;
                SPA  = {idx_q, sub_q[1:0]};
                // Registered RAM: the byte addressed on step k arrives on step k+1.
                case (sub_q)
                    4'd1: y_d = SPD;
                    4'd2: x_d[7:0] = SPD;
                    4'd3: code_d = SPD;
                    4'd4: begin
                        x_d[8]  = SPD[0];
                        hflip_d = SPD[1];
                        vflip_d = SPD[2];
                    end
                    default: begin
                    end
                endcase
                if (sub_q == 4'd4) begin
                    sub_d   = '0;
                    state_d = StCheck;
                end else begin
                    sub_d = sub_q + 4'd1;
                end
            end
            StCheck: begin
                BUSY = 1'b1;
                if (diff < 8'd16) begin
                    row_d  = vflip_q ? ~diff[3:0] : diff[3:0];
                    half_d = 1'b0;
`ifdef SPRITE_LIMIT_EN
                    if (hit_q >= 7'(MAXLINE)) begin
                        ovf_d   = 1'b1;
                        state_d = StNext;
                    end else begin
                        hit_d   = hit_q + 7'd1;
                        state_d = StFetch;
                    end
`else
                    state_d = StFetch;
`endif
                end else begin
                    state_d = StNext;
                end
            end
            StFetch: begin
                BUSY   = 1'b1;
                ROM_RD = 1'b1;
                ROM_AD = {code_q, row_q, half_q};
                if (ROM_OK) begin
                    if (!half_q) begin
                        pix_d[63:32] = ROM_DT;
                        half_d       = 1'b1;
                    end else begin
                        pix_d[31:0] = ROM_DT;
                        sub_d       = '0;
                        state_d     = StDraw;
                    end
                end
            end
            StDraw: begin
                BUSY = 1'b1;
                WEN  = (pixel != 4'd0);
                WAD  = {vpos_q[0], x_q + 9'(sub_q)};
                WDT  = pixel;
                if (sub_q == 4'd15) begin
                    state_d = StNext;
                end else begin
                    sub_d = sub_q + 4'd1;
                end
            end
            StNext: begin
                BUSY = 1'b1;
                if (idx_q == 6'(NSPR - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    sub_d   = '0;
                    state_d = StAttr;
                end
            end
            StDone: begin
                DONE    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A new line always wins, abandoning whatever sprite was in flight.
        if (LINE_START) begin
            state_d = StAttr;
            vpos_d  = VPOS;
            idx_d   = '0;
            sub_d   = '0;
`ifdef SPRITE_LIMIT_EN
            hit_d   = '0;
            ovf_d   = 1'b0;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            vpos_q  <= '0;
            idx_q   <= '0;
            sub_q   <= '0;
            y_q     <= '0;
            x_q     <= '0;
            code_q  <= '0;
            hflip_q <= 1'b0;
            vflip_q <= 1'b0;
            row_q   <= '0;
            half_q  <= 1'b0;
            pix_q   <= '0;
`ifdef SPRITE_LIMIT_EN
            hit_q   <= '0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vpos_q  <= vpos_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            y_q     <= y_d;
            x_q     <= x_d;
            code_q  <= code_d;
            hflip_q <= hflip_d;
            vflip_q <= vflip_d;
            row_q   <= row_d;
            half_q  <= half_d;
            pix_q   <= pix_d;
`ifdef SPRITE_LIMIT_EN
            hit_q   <= hit_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: doc/sprite_line_writer.md
Name: sprite_line_writer

Overview:
Per-scanline sprite renderer feeding the 4bpp sprite line buffer (10-bit address, 4-bit data, write port WCL/WEN/WAD/WDT). On each LINE_START it scans sprite attribute RAM, selects sprites intersecting the target line, fetches their 16-pixel rows from sprite graphics ROM, and writes non-transparent pixels into the line-buffer bank for that line. The video read side consumes the other bank with read-and-clear while this block fills one.

Parameters:
NSPR, 64, sprite entries scanned per line (1..64); 4 attribute bytes each
MAXLINE, 8, max sprites drawn per line (used only with SPRITE_LIMIT_EN)

Ports:
CLK  in  1  system clock; also drives the line-buffer write clock
RESET  in  1  asynchronous, active-high
LINE_START  in  1  one-cycle pulse: begin rendering line VPOS
VPOS  in  8  target scanline, sampled on LINE_START
SPA  out  8  attribute RAM address {sprite[5:0], byte[1:0]}
SPD  in  8  attribute data, valid the cycle after SPA is presented (registered read)
ROM_AD  out  13  graphics ROM address {code[7:0], row[3:0], half}
ROM_RD  out  1  ROM request; held with ROM_AD stable until ROM_OK
ROM_OK  in  1  ROM data valid; ROM_DT captured this cycle
ROM_DT  in  32  8 pixels, 4bpp; leftmost pixel in [31:28]
WEN  out  1  line-buffer write strobe
WAD  out  10  line-buffer address {VPOS[0], X[8:0]}
WDT  out  4  pixel colour
BUSY  out  1  high from LINE_START until DONE
DONE  out  1  one-cycle pulse at end of line
OVF  out  1  sticky per line: more sprites hit than MAXLINE

Behaviour:
- Reset: all outputs 0; FSM to IDLE; sprite index 0.
- Attribute bytes: b0=Y, b1=X[7:0], b2=code, b3: bit0=X[8], bit1=hflip, bit2=vflip, other bits ignored.
- FSM: IDLE -> ATTR (LINE_START; latch VPOS, index=0, BUSY=1, OVF=0).
- ATTR: present SPA for bytes 0..3 on consecutive cycles; each byte captured one cycle later; 5 cycles per sprite, then CHECK.
- CHECK: diff = VPOS - Y (8-bit, mod 256). diff < 16 -> hit, row = vflip ? 15-diff[3:0] : diff[3:0], go FETCH. Else NEXT.
- FETCH: ROM_RD=1, ROM_AD={code,row,half}; fetch half 0, then half 1; 64-bit row buffer; hflip mirrors order of all 16 pixels. Then DRAW.
- DRAW: 16 cycles, pixel i on cycle i. WAD={VPOS[0], (X+i) mod 512}. WEN=1 only when pixel != 0 (colour 0 transparent). WDT=pixel.
- NEXT: index==NSPR-1 -> DONE state; else index+1 -> ATTR.
- DONE: DONE=1 for one cycle, BUSY=0, -> IDLE.
- Priority: later sprite index overwrites earlier at the same X (last writer wins).
- X wrap: X+i crosses 511 -> wraps to 0, no carry into WAD[9].
- LINE_START while BUSY: abort current sprite (any ROM request dropped, no further WEN), restart at index 0 with new VPOS; no DONE for aborted line.
- ROM_OK is honoured only while ROM_RD=1; ROM_OK at other times is ignored.
- RESET mid-line: immediate return to IDLE, all outputs 0.

Optional Feature:
SPRITE_LIMIT_EN: defined -> hit counter; a hit beyond MAXLINE sets OVF, skips FETCH/DRAW, and scanning continues (OVF reflects all overflows). Undefined -> no limit; OVF tied 0.

Test Plan:
- Single sprite Y=0x20 X=0x010 code=0x05, ROM row pixels 1..15,0 with VPOS=0x23 -> ROM_AD 0x0A6/0x0A7; 15 writes at WAD 0x210..0x21E; no write at 0x21F; DONE pulse; all other sprites miss.
- Same sprite with hflip+vflip -> ROM row 12 (ROM_AD 0x0B8/0x0B9); pixel order reversed; writes at 0x211..0x21F.
- X=0x1F8, VPOS=0x20 -> writes wrap 0x1F8..0x1FF then 0x000..0x007 in bank 0.
- ROM_OK delayed 5 cycles -> ROM_RD and ROM_AD held stable; correct pixels written; no WEN during wait.
- LINE_START mid-DRAW with new VPOS -> WEN stops next cycle; scan restarts at SPA=0x00; single DONE at end of the new line.
- SPRITE_LIMIT_EN, MAXLINE=8, 10 sprites on line -> exactly 8 drawn (indices lowest 8); OVF=1; without macro, 10 drawn and OVF=0.
